rx_byte_deframer: RTL and testbench
===================================

Name: rx_byte_deframer

Overview:
- Sits in the 250 MHz domain on the read side of the PHY-to-core CDC FIFO. The FIFO carries raw 8-bit RX bytes from the 125 MHz PHY domain.
- Drains the FIFO, strips preamble/SFD, detects end-of-frame by an inter-byte gap, and emits a framed byte stream (valid/sof/eof/err) to the packet parser.
- The FIFO carries no last-byte marker. Frame boundaries are therefore recovered from empty-gap timing. At 2:1 clock ratio the FIFO goes empty at most 1 cycle between bytes mid-frame.

Parameters:
- GAP_CYCLES, 4, consecutive empty read-domain cycles in PAYLOAD that end a frame (must be >= 3).
- MIN_PREAMBLE, 2, minimum 0x55 bytes required before 0xD5 SFD.
- MIN_FRAME_BYTES, 64, minimum post-SFD byte count; shorter frames are flagged with err.
- MAX_FRAME_BYTES, 1522, maximum post-SFD byte count; longer frames are flagged with err and truncated.

Ports:
- clkIn  in  1  250 MHz read-domain clock
- rstNIn  in  1  asynchronous active-low reset
- rdEmptyIn  in  1  FIFO empty
- rdRstBusyIn  in  1  FIFO read-side reset busy
- rdDataIn  in  8  FIFO dout; valid the cycle after rdEnOut is high (read latency 1)
- rdEnOut  out  1  FIFO pop
- dataOut  out  8  frame byte
- validOut  out  1  dataOut qualifier
- sofOut  out  1  first post-SFD byte, coincident with validOut
- eofOut  out  1  last byte of frame, coincident with validOut
- errOut  out  1  frame error, asserted only with eofOut
- frameLenOut  out  11  byte count of the frame, valid with eofOut
- idleOut  out  1  high in IDLE state

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0 except idleOut=1. Counters and holding register cleared.
- Pop rule: rdEnOut = ~rdEmptyIn & ~rdRstBusyIn, in every state. The block always drains; no backpressure exists.
- Byte capture: popped byte arrives 1 cycle later (rdVld = rdEnOut delayed by 1).
- States:
  - IDLE: on rdVld & byte==0x55, preCnt=1 -> PREAMBLE. Any other byte stays in IDLE and is discarded.
  - PREAMBLE: 0x55 -> preCnt++ (saturates at 7). 0xD5 with preCnt>=MIN_PREAMBLE -> PAYLOAD. 0xD5 with short preamble, or any other byte -> DROP.
  - PAYLOAD:
    - Each rdVld byte loads a 1-deep holding register.
    - The previously held byte is emitted (validOut=1) in the same cycle. The first emitted byte carries sofOut.
    - Gap counter increments on each cycle without rdVld and clears on rdVld.
    - When the gap counter reaches GAP_CYCLES, the held byte is emitted with eofOut=1, frameLenOut=len, and errOut=(len<MIN_FRAME_BYTES). Then -> IDLE.
    - If len would exceed MAX_FRAME_BYTES, the current held byte is emitted with eofOut=1, errOut=1, frameLenOut=MAX_FRAME_BYTES, then -> DROP.
  - DROP: discard bytes; gap counter reaching GAP_CYCLES -> IDLE. No outputs.
- Any state: gap counter reaching GAP_CYCLES in PREAMBLE -> IDLE silently.
- len counts emitted bytes including the final one. 11-bit width; saturation cannot occur due to the MAX check.
- Single-byte frame: sofOut and eofOut assert in the same cycle, with errOut=1.
- End-of-frame latency: eofOut asserts GAP_CYCLES+1 cycles after the last byte's rdVld.
- rdRstBusyIn high: no pops. A gap that results ends the frame normally via timeout.
- Reset mid-frame: outputs drop immediately. No eofOut is generated for the partial frame.

Optional Feature:
- Macro: RX_FCS_CHECK_EN.
- Defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is computed over all PAYLOAD bytes, including the 4 FCS bytes.
  - At eof, errOut additionally asserts if the residue != 0xC704DD7B.
  - fcsOkOut (out, 1) pulses with eofOut when the residue matches.
  - CRC state resets on SFD.
- Undefined: no CRC logic and no fcsOkOut port. errOut reflects length errors only.

Test Plan:
- Push 7x0x55, 0xD5, 64 bytes 0x00..0x3F at one byte every 2 cycles -> 64 validOut pulses, sofOut on 0x00, eofOut+0x3F with frameLenOut=64, errOut=0, eofOut 5 cycles after last rdVld.
- Frame of 10 payload bytes -> eofOut with frameLenOut=10, errOut=1.
- Preamble 1x0x55 then 0xD5 (MIN_PREAMBLE=2) followed by 64 bytes -> no validOut; idleOut returns after 4-cycle gap.
- 1600 payload bytes back-to-back -> eofOut+errOut at byte 1522, frameLenOut=1522, remaining 78 bytes dropped, idleOut after gap.
- Two 64-byte frames separated by 6 empty cycles -> two complete sof/eof sequences; a 2-cycle mid-frame gap does not split the frame.
- With RX_FCS_CHECK_EN: valid 64-byte frame with correct FCS -> fcsOkOut=1, errOut=0; flip bit 0 of byte 20 -> errOut=1, fcsOkOut=0. Deassert rstNIn mid-payload -> validOut=0 immediately, idleOut=1.

Source files
------------

// File: rtl/rx_byte_deframer.sv
// rx_byte_deframer: drains the PHY->core RX CDC FIFO, strips preamble/SFD,
// ends frames on an empty-gap timeout and emits a framed byte stream.
// Ports:
//   clkIn, rstNIn        250 MHz read clock, async active-low reset
//   rdEmptyIn            FIFO empty
//   rdRstBusyIn          FIFO read-side reset in progress
//   rdDataIn[7:0]        FIFO dout, valid the cycle after rdEnOut
//   rdEnOut              FIFO pop (always drains, no backpressure)
//   dataOut[7:0]         frame byte, qualified by validOut
//   validOut             byte strobe
//   sofOut               first post-SFD byte
//   eofOut               last byte of the frame
//   errOut               frame error (runt, oversize, bad FCS), with eofOut
//   frameLenOut[10:0]    emitted byte count, with eofOut
//   idleOut              high while in IDLE
//   fcsOkOut             FCS residue matched, with eofOut (RX_FCS_CHECK_EN)
// Build option: define RX_FCS_CHECK_EN to add CRC-32 FCS checking.
// rstNIn is expected to be release-synchronised to clkIn upstream.
module rx_byte_deframer #(
    parameter int GAP_CYCLES      = 4,
    parameter int MIN_PREAMBLE    = 2,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic        clkIn,
    input  logic        rstNIn,
    input  logic        rdEmptyIn,
    input  logic        rdRstBusyIn,
    input  logic [7:0]  rdDataIn,
    output logic        rdEnOut,
    output logic [7:0]  dataOut,
    output logic        validOut,
    output logic        sofOut,
    output logic        eofOut,
    output logic        errOut,
    output logic [10:0] frameLenOut,
`ifdef RX_FCS_CHECK_EN
    output logic        fcsOkOut,
`endif
    output logic        idleOut
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_SAT  = GW'(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [2:0]    PRE_MIN  = 3'(MIN_PREAMBLE);
    localparam logic [10:0]   MIN_LEN  = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0]   MAX_LEN  = 11'(MAX_FRAME_BYTES);
    localparam logic [7:0]    PRE_BYTE = 8'h55;
    localparam logic [7:0]    SFD_BYTE = 8'hD5;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DROP
    } stateT;

    stateT state;
    stateT stateNxt;

    logic          rdVld;
    logic [GW-1:0] gapCnt;
    logic [GW-1:0] gapNxt;
    logic          gapHit;

    logic [2:0]  preCnt;
    logic [2:0]  preCntNxt;
    logic [7:0]  holdData;
    logic [7:0]  holdNxt;
    logic        holdVld;
    logic        holdVldNxt;
    logic [10:0] len;
    logic [10:0] lenNxt;
    logic [10:0] lenInc;
    logic        first;
    logic        firstNxt;

    logic [7:0]  dataNxt;
    logic        validNxt;
    logic        sofNxt;
    logic        eofNxt;
    logic        errNxt;
    logic [10:0] frameLenNxt;

`ifdef RX_FCS_CHECK_EN
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    logic [31:0] crcReg;
    logic [31:0] crcNxt;
    logic [31:0] crcEmit;
    logic        fcsMatch;
    logic        fcsOkNxt;

    // LSB-first (reflected) CRC-32 update for one byte.
    function automatic logic [31:0] crcStep(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) begin
                r = (r >> 1) ^ CRC_POLY_REFL;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] bitRev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // The register holds the reflected remainder; the residue constant
    // is in normal bit order, so flip before comparing.
    assign crcEmit  = crcStep(crcReg, holdData);
    assign fcsMatch = (bitRev(crcEmit) == CRC_RESIDUE);
`endif

    assign rdEnOut = ~rdEmptyIn & ~rdRstBusyIn;
    assign idleOut = (state == IDLE);
    assign lenInc  = len + 11'd1;

    // Gap counter saturates so a long idle never wraps into a false hit.
    assign gapNxt = rdVld ? '0 :
                    (gapCnt == GAP_SAT) ? gapCnt : gapCnt + 1'b1;
    assign gapHit = ~rdVld & (gapCnt == GAP_LAST);

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt    = state;
        preCntNxt   = preCnt;
        holdNxt     = holdData;
        holdVldNxt  = holdVld;
        lenNxt      = len;
        firstNxt    = first;
        dataNxt     = '0;
        validNxt    = 1'b0;
        sofNxt      = 1'b0;
        eofNxt      = 1'b0;
        errNxt      = 1'b0;
        frameLenNxt = '0;
`ifdef RX_FCS_CHECK_EN
        crcNxt      = crcReg;
        fcsOkNxt    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                preCntNxt  = '0;
                holdVldNxt = 1'b0;
                lenNxt     = '0;
                firstNxt   = 1'b1;
                if (rdVld && rdDataIn == PRE_BYTE) begin
                    preCntNxt = 3'd1;
                    stateNxt  = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (rdVld) begin
                    if (rdDataIn == PRE_BYTE) begin
                        if (preCnt != 3'd7) begin
                            preCntNxt = preCnt + 3'd1;
                        end
                    end else if (rdDataIn == SFD_BYTE &&
                                 preCnt >= PRE_MIN) begin
                        stateNxt = PAYLOAD;
`ifdef RX_FCS_CHECK_EN
                        crcNxt   = '1;
`endif
                    end else begin
                        stateNxt = DROP;
                    end
                end else if (gapHit) begin
                    stateNxt = IDLE;
                end
            end
            PAYLOAD: begin
                if (rdVld) begin
                    // New byte replaces the held one, which goes out now.
                    holdNxt    = rdDataIn;
                    holdVldNxt = 1'b1;
                    if (holdVld) begin
                        validNxt = 1'b1;
                        dataNxt  = holdData;
                        sofNxt   = first;
                        firstNxt = 1'b0;
                        lenNxt   = lenInc;
`ifdef RX_FCS_CHECK_EN
                        crcNxt   = crcEmit;
`endif
                        // Byte MAX goes out while another is already
                        // arriving: close as oversize, drop the rest.
                        if (lenInc == MAX_LEN) begin
                            eofNxt      = 1'b1;
                            errNxt      = 1'b1;
                            frameLenNxt = MAX_LEN;
                            holdVldNxt  = 1'b0;
                            stateNxt    = DROP;
`ifdef RX_FCS_CHECK_EN
                            fcsOkNxt    = fcsMatch;
`endif
                        end
                    end
                end else if (gapHit) begin
                    stateNxt   = IDLE;
                    holdVldNxt = 1'b0;
                    if (holdVld) begin
                        validNxt    = 1'b1;
                        dataNxt     = holdData;
                        sofNxt      = first;
                        eofNxt      = 1'b1;
                        firstNxt    = 1'b0;
                        lenNxt      = lenInc;
                        frameLenNxt = lenInc;
                        errNxt      = (lenInc < MIN_LEN);
`ifdef RX_FCS_CHECK_EN
                        crcNxt      = crcEmit;
                        fcsOkNxt    = fcsMatch;
                        errNxt      = (lenInc < MIN_LEN) | ~fcsMatch;
`endif
                    end
                end
            end
            DROP: begin
                if (gapHit) begin
                    stateNxt = IDLE;
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            rdVld       <= 1'b0;
            gapCnt      <= '0;
            preCnt      <= '0;
            holdData    <= '0;
            holdVld     <= 1'b0;
            len         <= '0;
            first       <= 1'b0;
            dataOut     <= '0;
            validOut    <= 1'b0;
            sofOut      <= 1'b0;
            eofOut      <= 1'b0;
            errOut      <= 1'b0;
            frameLenOut <= '0;
        end else begin
            rdVld       <= rdEnOut;
            gapCnt      <= gapNxt;
            preCnt      <= preCntNxt;
            holdData    <= holdNxt;
            holdVld     <= holdVldNxt;
            len         <= lenNxt;
            first       <= firstNxt;
            dataOut     <= dataNxt;
            validOut    <= validNxt;
            sofOut      <= sofNxt;
            eofOut      <= eofNxt;
            errOut      <= errNxt;
            frameLenOut <= frameLenNxt;
        end
    end

`ifdef RX_FCS_CHECK_EN
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            crcReg   <= '1;
            fcsOkOut <= 1'b0;
        end else begin
            crcReg   <= crcNxt;
            fcsOkOut <= fcsOkNxt;
        end
    end
`endif

endmodule

// File: tb/tb_rx_byte_deframer.sv
// tb_rx_byte_deframer: directed + randomized frames checked against a
// frame-level reference model of the deframer.
module tb_rx_byte_deframer;

    localparam int GAP  = 4;
    localparam int MINP = 2;
    localparam int MINF = 64;
    localparam int MAXF = 1522;
    localparam int NC   = 4096;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        rdEmpty = 1'b1;
    logic        rdRstBusy = 1'b0;
    logic [7:0]  rdData = '0;
    logic        rdEnOut;
    logic [7:0]  dataOut;
    logic        validOut;
    logic        sofOut;
    logic        eofOut;
    logic        errOut;
    logic [10:0] frameLenOut;
    logic        idleOut;
`ifdef RX_FCS_CHECK_EN
    logic        fcsOkOut;
`endif

    rx_byte_deframer dut (
        .clkIn       (clk),
        .rstNIn      (rstN),
        .rdEmptyIn   (rdEmpty),
        .rdRstBusyIn (rdRstBusy),
        .rdDataIn    (rdData),
        .rdEnOut     (rdEnOut),
        .dataOut     (dataOut),
        .validOut    (validOut),
        .sofOut      (sofOut),
        .eofOut      (eofOut),
        .errOut      (errOut),
        .frameLenOut (frameLenOut),
`ifdef RX_FCS_CHECK_EN
        .fcsOkOut    (fcsOkOut),
`endif
        .idleOut     (idleOut)
    );

    always #2 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Schedule: per cycle, byte offered (-1 = FIFO empty) and busy flag.
    int sd[$];
    bit sb[$];

    bit         eV[NC];
    bit         eS[NC];
    bit         eE[NC];
    bit         eR[NC];
    bit         eF[NC];
    logic [7:0] eD[NC];
    int         eL[NC];

    bit         pPop = 1'b0;
    logic [7:0] pByte = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read-domain cycle; emulates the FIFO's 1-cycle read latency.
    task automatic drive(int b, bit busy);
        @(posedge clk);
        #1;
        rdData    = pPop ? pByte : 8'($urandom);
        rdEmpty   = (b < 0);
        rdRstBusy = busy;
        pPop      = (b >= 0) && !busy;
        pByte     = 8'(b);
    endtask

    task automatic pushE(int k);
        repeat (k) begin
            sd.push_back(-1);
            sb.push_back(1'b0);
        end
    endtask

    task automatic pushB(int b, int gapAfter);
        sd.push_back(b & 255);
        sb.push_back(1'b0);
        pushE(gapAfter);
    endtask

    task automatic pushBusy(int k);
        repeat (k) begin
            sd.push_back(int'($urandom_range(255)));
            sb.push_back(1'b1);
        end
    endtask

    // Standard Ethernet FCS: MSB-first CRC over bit-reversed input,
    // reflected and inverted at the end.
    function automatic logic [31:0] ethCrc(input int q[$], input int a,
                                           input int n);
        logic [31:0] c;
        logic [31:0] r;
        logic [7:0]  b;
        bit          fb;
        c = '1;
        for (int i = 0; i < n; i++) begin
            b = 8'(q[a+i]);
            for (int k = 0; k < 8; k++) begin
                fb = c[31] ^ b[k];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return ~r;
    endfunction

    function automatic bit fcsGood(input int q[$], input int a, input int n);
        logic [31:0] fcs;
        if (n < 4) return 1'b0;
        fcs = {8'(q[a+n-1]), 8'(q[a+n-2]), 8'(q[a+n-3]), 8'(q[a+n-4])};
        return ethCrc(q, a, n - 4) == fcs;
    endfunction

    // Frame-level model: bytes arrive one cycle after their pop; bytes
    // separated by fewer than GAP empty cycles form one burst.  Within a
    // burst: leading non-0x55 junk, a run of 0x55, then 0xD5 with a long
    // enough run opens a frame holding the rest of the burst.  Each byte
    // is seen on the output one cycle after the next byte arrives; the
    // last one GAP+1 cycles after it arrived.
    task automatic buildModel(int n);
        int vc[$];
        int vb[$];
        int i;
        int j;
        int k;
        int m;
        int p0;
        int cnt;
        int cyc;
        bit trunc;
        for (int c = 0; c < NC; c++) begin
            eV[c] = 0; eS[c] = 0; eE[c] = 0; eR[c] = 0; eF[c] = 0;
            eD[c] = '0; eL[c] = 0;
        end
        for (int c = 0; c < n; c++) begin
            if (sd[c] >= 0 && !sb[c]) begin
                vc.push_back(c + 1);
                vb.push_back(sd[c]);
            end
        end
        i = 0;
        while (i < vc.size()) begin
            j = i + 1;
            while (j < vc.size() && vc[j] - vc[j-1] - 1 < GAP) j++;
            k = i;
            while (k < j && vb[k] != 8'h55) k++;
            m = 0;
            while (k + m < j && vb[k+m] == 8'h55) m++;
            p0 = k + m + 1;
            if (k < j && k + m < j && vb[k+m] == 8'hD5 && m >= MINP) begin
                cnt   = j - p0;
                trunc = (cnt > MAXF);
                if (trunc) cnt = MAXF;
                for (int q = 0; q < cnt; q++) begin
                    if (q < cnt - 1 || trunc) cyc = vc[p0+q+1] + 1;
                    else                      cyc = vc[p0+q] + GAP + 1;
                    if (cyc < NC) begin
                        eV[cyc] = 1'b1;
                        eD[cyc] = 8'(vb[p0+q]);
                        eS[cyc] = (q == 0);
                        eE[cyc] = (q == cnt - 1);
                        if (q == cnt - 1) begin
                            eL[cyc] = cnt;
                            eR[cyc] = trunc || (cnt < MINF);
`ifdef RX_FCS_CHECK_EN
                            eF[cyc] = fcsGood(vb, p0, cnt);
                            eR[cyc] = eR[cyc] || !eF[cyc];
`endif
                        end
                    end
                end
            end
            i = j;
        end
    endtask

    task automatic runSched(string tag);
        int n;
        pushE(GAP + 8);
        n = sd.size();
        chk({tag, ".fits"}, 32'(n < NC), 32'd1);
        buildModel(n);
        for (int c = 0; c < n && c < NC; c++) begin
            drive(sd[c], sb[c]);
            @(negedge clk);
            chk({tag, ".rdEn"}, 32'(rdEnOut), 32'(sd[c] >= 0 && !sb[c]));
            chk({tag, ".valid"}, 32'(validOut), 32'(eV[c]));
            chk({tag, ".flags"}, 32'({sofOut, eofOut, errOut}),
                32'({eS[c], eE[c], eR[c]}));
            if (eV[c]) chk({tag, ".data"}, 32'(dataOut), 32'(eD[c]));
            if (eE[c]) chk({tag, ".len"}, 32'(frameLenOut), 32'(eL[c]));
            if (eV[c] && !eE[c]) chk({tag, ".busyIdle"}, 32'(idleOut), 32'd0);
`ifdef RX_FCS_CHECK_EN
            chk({tag, ".fcsOk"}, 32'(fcsOkOut), 32'(eF[c]));
`endif
        end
        chk({tag, ".endIdle"}, 32'(idleOut), 32'd1);
        sd.delete();
        sb.delete();
    endtask

    task automatic pushHdr(int n55, int sfd, int sp);
        repeat (n55) pushB(8'h55, sp);
        pushB(sfd, sp);
    endtask

    task automatic pushRand(int n, int spMax);
        repeat (n) pushB(int'($urandom_range(255)), int'($urandom_range(spMax)));
    endtask

    initial begin
        int fl;
        int sp;
        int q[$];
        logic [31:0] c;

        rstN = 1'b0;
        repeat (3) drive(-1, 1'b0);
        @(negedge clk);
        chk("rst.valid", 32'(validOut), 32'd0);
        chk("rst.flags", 32'({sofOut, eofOut, errOut}), 32'd0);
        chk("rst.data", 32'(dataOut), 32'd0);
        chk("rst.len", 32'(frameLenOut), 32'd0);
        chk("rst.idle", 32'(idleOut), 32'd1);
        chk("rst.rdEn", 32'(rdEnOut), 32'd0);
        @(posedge clk);
        #1 rstN = 1'b1;

        // Nominal 64-byte frame at half rate.
        pushHdr(7, 8'hD5, 1);
        for (int b = 0; b < 64; b++) pushB(b, 1);
        runSched("s1");

        // Runt frame.
        pushHdr(3, 8'hD5, 0);
        pushRand(10, 1);
        runSched("s2");

        // Short preamble: whole burst dropped.
        pushHdr(1, 8'hD5, 1);
        pushRand(64, 0);
        runSched("s3");

        // Oversize: truncated at MAXF, rest dropped.
        pushHdr(2, 8'hD5, 0);
        pushRand(1600, 0);
        runSched("s4");

        // Two frames; mid-frame 2-cycle hole must not split the first.
        pushHdr(2, 8'hD5, 0);
        for (int b = 0; b < 64; b++) pushB(int'($urandom_range(255)),
                                           (b == 30) ? 2 : (b == 63) ? 6 : 0);
        pushHdr(2, 8'hD5, 1);
        pushRand(64, 1);
        runSched("s5");

        // Single-byte frame, empty payload, min-length boundary.
        pushHdr(2, 8'hD5, 0);
        pushB(8'hAB, 6);
        pushHdr(2, 8'hD5, 6);
        pushHdr(2, 8'hD5, 0);
        pushRand(63, 0);
        pushE(5);
        pushHdr(2, 8'hD5, 0);
        pushRand(64, 0);
        runSched("s6");

        // Exactly MAXF bytes is a good frame.
        pushHdr(2, 8'hD5, 0);
        pushRand(MAXF, 0);
        runSched("s7");

        // FIFO reset-busy: short stall keeps the frame, long one ends it.
        pushHdr(3, 8'hD5, 0);
        pushRand(20, 0);
        pushBusy(2);
        pushRand(50, 1);
        pushBusy(6);
        pushRand(10, 0);
        runSched("s8");

        // Random frames: junk, random preamble/SFD, spacing, gaps.
        for (int f = 0; f < 8; f++) begin
            pushRand(int'($urandom_range(3)), 0);
            sp = int'($urandom_range(2));
            pushHdr(int'($urandom_range(4)),
                    ($urandom_range(5) == 0) ? 8'hD4 : 8'hD5, sp);
            fl = int'($urandom_range(100, 1));
            pushRand(fl, 2);
            pushE(int'($urandom_range(8, 4)));
        end
        runSched("s9");

`ifdef RX_FCS_CHECK_EN
        for (int v = 0; v < 2; v++) begin
            q.delete();
            for (int b = 0; b < 60; b++) q.push_back(int'($urandom_range(255)));
            c = ethCrc(q, 0, 60);
            for (int b = 0; b < 4; b++) q.push_back(int'(c[8*b +: 8]));
            if (v == 1) q[20] = q[20] ^ 1;
            pushHdr(2, 8'hD5, 0);
            foreach (q[b]) pushB(q[b], 1);
            pushE(6);
        end
        runSched("fcs");
`endif

        // Reset in mid-payload: outputs drop at once, no eof afterwards.
        q.delete();
        q.push_back(8'h55);
        q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int b = 0; b < 10; b++) q.push_back(int'($urandom_range(255)));
        for (int b = 0; b < 9; b++) drive(q[b], 1'b0);
        @(negedge clk);
        chk("mid.valid", 32'(validOut), 32'd1);
        chk("mid.idle", 32'(idleOut), 32'd0);
        #1 rstN = 1'b0;
        #1;
        chk("rstMid.valid", 32'(validOut), 32'd0);
        chk("rstMid.idle", 32'(idleOut), 32'd1);
        chk("rstMid.flags", 32'({sofOut, eofOut, errOut}), 32'd0);
        repeat (3) drive(-1, 1'b0);
        rstN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(-1, 1'b0);
            @(negedge clk);
            chk("post.valid", 32'(validOut), 32'd0);
            chk("post.eof", 32'(eofOut), 32'd0);
        end
        chk("post.idle", 32'(idleOut), 32'd1);

        // Normal traffic after the reset.
        pushHdr(2, 8'hD5, 1);
        pushRand(70, 1);
        runSched("s10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
